tank_sprite_arbiter: RTL and testbench



---
 rtl/tank_pkg.sv | 15 +
 rtl/tank_sprite_arbiter_if.sv | 39 +++
 rtl/rr_arbiter.sv | 38 +++
 rtl/tank_sprite_arbiter.sv | 87 ++++++++
 tb/tb_tank_sprite_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/tank_pkg.sv
// Shared sprite definitions for the tank renderers.
// Holds direction encoding, sprite address width and palette index width.
package tank_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   localparam int SPRITE_ADDR_W = 10;
   localparam int PAL_IDX_W     = 2;

endpackage

// File: rtl/tank_sprite_arbiter_if.sv
// Requester/ROM/response bundle of the tank sprite arbiter.
// master: renderers + ROM side; slave: the arbiter.
interface tank_sprite_arbiter_if
   import tank_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = SPRITE_ADDR_W
);

   localparam int ID_W = $clog2(N_REQ);

   logic                    frame_start;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*2-1:0]      req_dir;
   logic [N_REQ-1:0]        req_enemy;
   logic [N_REQ-1:0]        gnt;
   logic [ADDR_W+1:0]       rom_addr;
   logic [PAL_IDX_W-1:0]    rom_q;
   logic                    rsp_valid;
   logic [ID_W-1:0]         rsp_id;
   logic [PAL_IDX_W-1:0]    rsp_index;
   logic                    rsp_enemy;

   modport master (
      output frame_start, req, req_addr,
      output req_dir, req_enemy, rom_q,
      input  gnt, rom_addr, rsp_valid,
      input  rsp_id, rsp_index, rsp_enemy
   );

   modport slave (
      input  frame_start, req, req_addr,
      input  req_dir, req_enemy, rom_q,
      output gnt, rom_addr, rsp_valid,
      output rsp_id, rsp_index, rsp_enemy
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr_i, wraps at N.
// Ports: req_i, ptr_i in; gnt_o one-hot, winner_o binary, any_o out.
module rr_arbiter #(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] gnt_o,
   output logic [W-1:0] winner_o,
   output logic         any_o
);

   int          idx;
   logic [W-1:0] sel;
   logic         found;

   always_comb begin
      gnt_o    = '0;
      winner_o = '0;
      any_o    = 1'b0;
      found    = 1'b0;
      idx      = 0;
      sel      = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_i) + k;
         if (idx >= N) idx = idx - N;
         sel = W'(idx);
         if (!found && req_i[sel]) begin
            found      = 1'b1;
            gnt_o[sel] = 1'b1;
            winner_o   = sel;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/tank_sprite_arbiter.sv
// Shares one tank sprite ROM among N_REQ renderers, tags responses.
// Ports: clk, rst_n (async, low); bus = requests, ROM, responses.
module tank_sprite_arbiter
   import tank_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = SPRITE_ADDR_W,
   parameter int ROM_LAT = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   tank_sprite_arbiter_if.slave  bus
);

   localparam int ID_W = $clog2(N_REQ);
   localparam int RA_W = ADDR_W + 2;
   // One stage lines up with rom_addr, ROM_LAT more follow the ROM.
   localparam int TAG_D = ROM_LAT + 1;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic            enemy;
   } tag_t;

   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] arb_ptr, win;
   logic [N_REQ-1:0] gnt;
   logic             any;
   logic [RA_W-1:0]  rom_addr_q, rom_addr_d;
   tag_t             tag_d;
   tag_t             tag_q [TAG_D];

   // frame_start restarts priority at requester 0 in the same cycle.
   assign arb_ptr = bus.frame_start ? '0 : rr_ptr_q;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req_i    (bus.req),
      .ptr_i    (arb_ptr),
      .gnt_o    (gnt),
      .winner_o (win),
      .any_o    (any)
   );

   assign bus.gnt = gnt;

   always_comb begin
      rom_addr_d = rom_addr_q;
      rr_ptr_d   = rr_ptr_q;
      tag_d      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            rom_addr_d = {bus.req_dir[2*i +: 2],
                          bus.req_addr[i*ADDR_W +: ADDR_W]};
         end
      end
      if (any) begin
         rr_ptr_d    = (win == ID_W'(N_REQ-1)) ? '0
                                              : win + ID_W'(1);
         tag_d.valid = 1'b1;
         tag_d.id    = win;
         tag_d.enemy = |(gnt & bus.req_enemy);
      end else if (bus.frame_start) begin
         rr_ptr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr_q <= '0;
         rr_ptr_q   <= '0;
         for (int i = 0; i < TAG_D; i++) tag_q[i] <= '0;
      end else begin
         rom_addr_q <= rom_addr_d;
         rr_ptr_q   <= rr_ptr_d;
         tag_q[0]   <= tag_d;
         for (int i = 1; i < TAG_D; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign bus.rom_addr  = rom_addr_q;
   assign bus.rsp_valid = tag_q[TAG_D-1].valid;
   assign bus.rsp_id    = tag_q[TAG_D-1].id;
   assign bus.rsp_enemy = tag_q[TAG_D-1].enemy;
   assign bus.rsp_index = bus.rom_q;

endmodule

// File: tb/tb_tank_sprite_arbiter.sv
// Bench for tank_sprite_arbiter: vector table plus response scoreboard.
// Includes a two-stage ROM model driven from rom_addr.
module tb_tank_sprite_arbiter;
   import tank_pkg::*;

   localparam int N   = 4;
   localparam int AW  = 10;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   tank_sprite_arbiter_if #(.N_REQ(N), .ADDR_W(AW)) bus ();

   tank_sprite_arbiter #(
      .N_REQ(N), .ADDR_W(AW), .ROM_LAT(LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [1:0] rom_fn(input logic [11:0] a);
      return a[1:0] ^ a[5:4] ^ a[7:6] ^ a[11:10] ^ {a[3], a[8]};
   endfunction

   logic [1:0] rom_p1;
   always @(posedge clk) begin
      rom_p1    <= rom_fn(bus.rom_addr);
      bus.rom_q <= rom_p1;
   end

   typedef struct {
      int         id;
      logic       enemy;
      logic [1:0] idx;
      int         due;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic       fs;
      logic [3:0] req;
      logic [3:0] en;
      logic [3:0] eg;
   } vec_t;
   vec_t vt [18];

   logic [AW-1:0] addr [N];
   logic [1:0]    dirs [N];
   logic [11:0]   exp_ra = '0;

   task automatic check(input string nm,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Response monitor: every due entry must appear on time, nothing else.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
         check("rsp_enemy", 32'(bus.rsp_enemy), 32'(e.enemy));
         check("rsp_index", 32'(bus.rsp_index), 32'(e.idx));
      end else if (bus.rsp_valid !== 1'b0) begin
         n_tests++;
         n_fail++;
         $display("FAIL spurious_rsp: got rsp_valid=%b id=%0d expected 0",
                  bus.rsp_valid, bus.rsp_id);
      end
   end

   task automatic drive(input logic fs,
                        input logic [3:0] r,
                        input logic [3:0] en);
      bus.frame_start = fs;
      bus.req         = r;
      bus.req_enemy   = en;
      for (int i = 0; i < N; i++) begin
         bus.req_addr[i*AW +: AW] = addr[i];
         bus.req_dir[i*2 +: 2]    = dirs[i];
      end
   endtask

   task automatic step(input logic fs,
                       input logic [3:0] r,
                       input logic [3:0] en,
                       input logic [3:0] eg,
                       input bit push,
                       input string nm);
      int id;
      logic [11:0] ra;
      exp_t e;
      @(posedge clk);
      #1 drive(fs, r, en);
      @(negedge clk);
      check({nm, "_gnt"}, 32'(bus.gnt), 32'(eg));
      check({nm, "_rom_addr"}, 32'(bus.rom_addr), 32'(exp_ra));
      if (eg != 4'b0) begin
         id = 0;
         for (int i = 0; i < N; i++) if (eg[i]) id = i;
         ra     = {dirs[id], addr[id]};
         exp_ra = ra;
         addr[id] = addr[id] + 10'd1;
         if (push) begin
            e.id    = id;
            e.enemy = en[id];
            e.idx   = rom_fn(ra);
            e.due   = cyc + 3;
            sb.push_back(e);
         end
      end
   endtask

   task automatic drain(input string nm);
      for (int k = 0; k < 10 && sb.size() > 0; k++)
         step(1'b0, 4'b0, 4'b0, 4'b0, 1'b0, nm);
      check({nm, "_empty"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] r;
      addr[0] = 10'h3C1;
      addr[1] = 10'h2F0;
      addr[2] = 10'h05A;
      addr[3] = 10'h1E7;
      for (int i = 0; i < N; i++) dirs[i] = 2'(i);

      vt = '{
         '{1'b0, 4'b0100, 4'b0000, 4'b0100},
         '{1'b0, 4'b0000, 4'b0000, 4'b0000},
         '{1'b0, 4'b0000, 4'b0000, 4'b0000},
         '{1'b1, 4'b1111, 4'b1110, 4'b0001},
         '{1'b0, 4'b1111, 4'b1110, 4'b0010},
         '{1'b0, 4'b1111, 4'b1110, 4'b0100},
         '{1'b0, 4'b1111, 4'b1110, 4'b1000},
         '{1'b0, 4'b1111, 4'b1110, 4'b0001},
         '{1'b0, 4'b1111, 4'b1110, 4'b0010},
         '{1'b0, 4'b1010, 4'b0101, 4'b1000},
         '{1'b0, 4'b1010, 4'b0101, 4'b0010},
         '{1'b0, 4'b0100, 4'b0101, 4'b0100},
         '{1'b1, 4'b1001, 4'b0101, 4'b0001},
         '{1'b0, 4'b1001, 4'b0101, 4'b1000},
         '{1'b0, 4'b0010, 4'b0000, 4'b0010},
         '{1'b1, 4'b0000, 4'b0000, 4'b0000},
         '{1'b0, 4'b0110, 4'b1000, 4'b0010},
         '{1'b0, 4'b0011, 4'b0001, 4'b0001}
      };

      drive(1'b0, 4'b0, 4'b0);

      // Reset held: grant is combinational from pointer 0.
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1 r = 4'($urandom_range(1, 15));
         drive(1'($urandom_range(0, 1)), r, 4'($urandom));
         @(negedge clk);
         check("rst_gnt", 32'(bus.gnt), 32'(r & (~r + 4'd1)));
         check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
         check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
         check("rst_rsp_enemy", 32'(bus.rsp_enemy), 32'd0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1'b0, 4'b0, 4'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
         @(posedge clk);
      end

      for (int v = 0; v < 18; v++)
         step(vt[v].fs, vt[v].req, vt[v].en, vt[v].eg, 1'b1,
              $sformatf("vec%0d", v));
      drain("drain1");

      // Three grants in flight, then an asynchronous reset pulse.
      step(1'b0, 4'b1111, 4'b0110, 4'b0010, 1'b0, "mid0");
      step(1'b0, 4'b1111, 4'b0110, 4'b0100, 1'b0, "mid1");
      step(1'b0, 4'b1111, 4'b0110, 4'b1000, 1'b0, "mid2");
      @(posedge clk);
      #2 rst_n = 1'b0;
      drive(1'b0, 4'b0, 4'b0);
      #1;
      check("mid_async_valid", 32'(bus.rsp_valid), 32'd0);
      check("mid_async_addr", 32'(bus.rom_addr), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_ra = '0;
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 4'b0, 4'b0, 4'b0, 1'b0, "mid_idle");
         check("mid_no_stale", 32'(bus.rsp_valid), 32'd0);
      end

      step(1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b1, "resume");
      drain("drain2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
